// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl
// Description : I-cache line refill sequencer. Requests a 4-word burst for a
//               missed line, writes every beat into the data array, forwards
//               the critical word as it arrives and commits the tag/valid
//               entry only once all four words are in place.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_valid,
  input  logic [31:0] miss_addr,
  output logic        miss_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rerr,
  output logic        dwr_en,
  output logic [5:0]  dwr_index,
  output logic [1:0]  dwr_offset,
  output logic [31:0] dwr_data,
  output logic        tag_we,
  output logic [5:0]  tag_index,
  output logic [21:0] tag_value,
  output logic        fwd_valid,
  output logic [31:0] fwd_data,
  output logic        refill_done,
  output logic        refill_err,
  output logic        busy
);

  localparam int                 c_TMO_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_BEAT   = 3'd2,
    S_COMMIT = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:2]          r_addr;     // byte-offset bits never matter for a word fetch
  logic [1:0]           r_beat;
  logic [c_TMO_W-1:0]   r_tmo;
  logic                 w_beat_ok;
  logic                 w_tmo_hit;
  logic                 w_unused;

  assign w_beat_ok = mem_rvalid & ~mem_rerr;
  assign w_tmo_hit = (r_tmo == c_TMO_MAX);
  assign w_unused  = ^miss_addr[1:0];

  // State register; reset drops every strobe at once since outputs decode the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latched miss address, beat counter and no-progress timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_beat <= '0;
      r_tmo  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (miss_valid) begin
            r_addr <= miss_addr[31:2];
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            r_beat <= '0;
            r_tmo  <= '0;
          end else begin
            r_tmo <= r_tmo + c_TMO_W'(1);
          end
        end
        S_BEAT: begin
          if (w_beat_ok) begin
            r_beat <= r_beat + 2'd1;
            r_tmo  <= '0;
          end else if (!mem_rvalid) begin
            r_tmo <= r_tmo + c_TMO_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state decode and all outputs; beat data passes straight through to the array
  always_comb begin
    w_state_nxt = r_state;
    miss_ready  = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    dwr_en      = 1'b0;
    dwr_index   = '0;
    dwr_offset  = '0;
    dwr_data    = '0;
    tag_we      = 1'b0;
    tag_index   = '0;
    tag_value   = '0;
    fwd_valid   = 1'b0;
    fwd_data    = '0;
    refill_done = 1'b0;
    refill_err  = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        miss_ready = miss_valid;
        if (miss_valid) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {r_addr[31:4], 4'b0000};
        if (mem_gnt) begin
          w_state_nxt = S_BEAT;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_ERR;
        end
      end
      S_BEAT: begin
        if (mem_rvalid) begin
          if (mem_rerr) begin
            w_state_nxt = S_ERR;
          end else begin
            dwr_en     = 1'b1;
            dwr_index  = r_addr[9:4];
            dwr_offset = r_beat;
            dwr_data   = mem_rdata;
            if (r_beat == r_addr[3:2]) begin
              fwd_valid = 1'b1;
              fwd_data  = mem_rdata;
            end
            if (r_beat == 2'd3) begin
              w_state_nxt = S_COMMIT;
            end
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = S_ERR;
        end
      end
      S_COMMIT: begin
        // The tag goes valid only now, after all four words are written
        tag_we      = 1'b1;
        refill_done = 1'b1;
        tag_index   = r_addr[9:4];
        tag_value   = r_addr[31:10];
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        refill_err  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
